clk_gate_ctrl: RTL



---
 rtl/clk_ctrl_pkg.sv | 20 ++
 rtl/clk_gate_cnt.sv | 38 +++
 rtl/clk_gate_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the clock-gating controller.
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        IDLE_CNT = 3'd1,
        QUIESCE  = 3'd2,
        GATED    = 3'd3,
        WAKE     = 3'd4
    } gate_state_e;

    localparam int IDLE_CYCLES_DEFAULT = 16;
    localparam int WAKE_CYCLES_DEFAULT = 2;

    // Larger of two integers, used to size the shared counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_gate_cnt.sv
// Saturating up-counter with synchronous clear and terminal-count compare.
// clr_i and inc_i together load the value 1.
module clk_gate_cnt #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] base;
    logic [W-1:0] cnt_d;

    // Next count: clear first, then increment unless already at all-ones.
    always_comb begin
        base  = clr_i ? '0 : cnt_o;
        cnt_d = base;
        if (inc_i && (base != {W{1'b1}})) begin
            cnt_d = base + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else begin
            cnt_o <= cnt_d;
        end
    end

    assign tc_o = (cnt_o == limit_i);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable controller for one ICG: idle detection, quiesce handshake,
// gating and timed wake-up. Every output is a flop so the latch-based
// ICG never sees a combinational path from the inputs.
//
// Handshake: quiesce_req_o stays high for as long as the controller sits in
// QUIESCE; the domain answers with quiesce_ack_i high, which is only honoured
// in a cycle where no abort (busy/wake/force) is also sampled. An abort drops
// the request on the next cycle; ack outside QUIESCE is ignored.
module clk_gate_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEFAULT,
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        busy_i,
    input  logic        wake_i,
    input  logic        force_on_i,
    output logic        quiesce_req_o,
    input  logic        quiesce_ack_i,
    output logic        clk_en_o,
    output logic        ready_o,
    output logic        gated_o,
    output gate_state_e state_o
);

    localparam int CNT_W = $clog2(max_int(IDLE_CYCLES, WAKE_CYCLES) + 1);

    gate_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic             cnt_tc;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             abort;
    logic             gate_seen_q;
    logic             wake_pend_q, wake_pend_d;

    // Any of these keeps (or brings back) the clock running.
    assign abort = force_on_i | wake_i | busy_i;

    // One counter serves both the idle run and the wake settle window.
    assign limit = (state_q == WAKE) ? CNT_W'(WAKE_CYCLES) : CNT_W'(IDLE_CYCLES);

    clk_gate_cnt #(.W(CNT_W)) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .limit_i (limit),
        .cnt_o   (cnt),
        .tc_o    (cnt_tc)
    );

    // Next-state and counter control.
    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        wake_pend_d = 1'b0;
        case (state_q)
            RUN: begin
                cnt_clr = 1'b1;
                if (!abort) begin
                    state_d = IDLE_CNT;
                    cnt_inc = 1'b1;
                end
            end
            IDLE_CNT: begin
                if (abort) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    state_d = QUIESCE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            QUIESCE: begin
                cnt_clr = 1'b1;
                if (abort) begin
                    state_d = RUN;
                end else if (quiesce_ack_i) begin
                    state_d = GATED;
                end
            end
            GATED: begin
                cnt_clr = 1'b1;
                // The first gated cycle is a mandatory dwell so the enable is
                // low for at least two cycles; a wake seen then is held over.
                if (!gate_seen_q) begin
                    wake_pend_d = abort;
                end else if (abort || wake_pend_q) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                if (cnt_tc) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            gate_seen_q   <= 1'b0;
            wake_pend_q   <= 1'b0;
            clk_en_o      <= 1'b1;
            ready_o       <= 1'b1;
            quiesce_req_o <= 1'b0;
            gated_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            gate_seen_q   <= (state_q == GATED);
            wake_pend_q   <= wake_pend_d;
            clk_en_o      <= (state_d != GATED);
            ready_o       <= (state_d == RUN) || (state_d == IDLE_CNT) || (state_d == QUIESCE);
            quiesce_req_o <= (state_d == QUIESCE);
            gated_o       <= (state_d == GATED);
        end
    end

    assign state_o = state_q;

endmodule
